mem_dma: RTL and testbench

MEM_DMA -- requirements
Module: mem_dma

---
 rtl/mem_dma_pkg.sv | 16 +
 rtl/mem_dma.sv | 140 ++++++++++++++
 tb/tb_mem_dma.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory-to-memory DMA engine: FSM state
// encoding and the command mode constants.
package mem_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma.sv
// Memory DMA engine. Copies len words from src to dst through a single
// memory port (read then write, 2 cycles per word) or fills len words at
// dst with a constant pattern (1 cycle per word). Addresses wrap modulo
// the memory size. The memory port outputs are decoded combinationally
// from the state and registered counters so they line up with the cycle
// in which the memory samples them.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int DATA = 18,
  parameter int ADDR = 14
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [ADDR-1:0] src_addr,
  input  logic [ADDR-1:0] dst_addr,
  input  logic [ADDR:0]   len,
  input  logic [DATA-1:0] fill_data,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic            m_wr,
  output logic [ADDR-1:0] m_addr,
  output logic [DATA-1:0] m_din,
  input  logic [DATA-1:0] m_dout
);

  state_t          state_reg, state_next;
  logic [ADDR:0]   cnt_reg;
  logic            mode_reg;
  logic [ADDR-1:0] src_reg;
  logic [ADDR-1:0] dst_reg;
  logic [ADDR:0]   len_reg;
  logic [DATA-1:0] fill_reg;
  logic            aborted_reg;

  // The word being moved this cycle is the last one of the command.
  logic last_word;
  assign last_word = ((cnt_reg + 1'b1) == len_reg);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode; abort in RD skips the write, in WR/FILL it lets
  // the current write finish before terminating.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (len == '0)              state_next = ST_DONE;
          else if (mode == MODE_FILL) state_next = ST_FILL;
          else                        state_next = ST_RD;
        end
      end
      ST_RD:   state_next = abort ? ST_DONE : ST_WR;
      ST_WR:   state_next = (abort || last_word) ? ST_DONE : ST_RD;
      ST_FILL: state_next = (abort || last_word) ? ST_DONE : ST_FILL;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch, word counter and abort flag. An abort that lands on
  // the final write is a normal completion, so aborted stays clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      mode_reg    <= MODE_COPY;
      src_reg     <= '0;
      dst_reg     <= '0;
      len_reg     <= '0;
      fill_reg    <= '0;
      aborted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cnt_reg     <= '0;
            mode_reg    <= mode;
            src_reg     <= src_addr;
            dst_reg     <= dst_addr;
            len_reg     <= len;
            fill_reg    <= fill_data;
            aborted_reg <= 1'b0;
          end
        end
        ST_RD: begin
          if (abort) aborted_reg <= 1'b1;
        end
        ST_WR, ST_FILL: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (abort && !last_word) aborted_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status and memory port decode; the port idles at zero outside the
  // read/write states.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    aborted = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_din   = '0;
    case (state_reg)
      ST_RD: begin
        busy   = 1'b1;
        m_addr = src_reg + cnt_reg[ADDR-1:0];
      end
      ST_WR: begin
        busy   = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_reg + cnt_reg[ADDR-1:0];
        m_din  = m_dout;
      end
      ST_FILL: begin
        busy   = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_reg + cnt_reg[ADDR-1:0];
        m_din  = fill_reg;
      end
      ST_DONE: begin
        done    = 1'b1;
        aborted = aborted_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: a behavioural memory with 1-cycle read
// latency, plus a word-level reference model of each command.
module tb_mem_dma;

  localparam int DATA  = 18;
  localparam int ADDR  = 14;
  localparam int DEPTH = 1 << ADDR;

  logic            clk = 1'b0;
  logic            reset, start, mode, abort;
  logic [ADDR-1:0] src_addr, dst_addr, m_addr;
  logic [ADDR:0]   len;
  logic [DATA-1:0] fill_data, m_din, m_dout;
  logic            busy, done, aborted, m_wr;

  logic            ld_en;
  logic [ADDR-1:0] ld_addr;
  logic [DATA-1:0] ld_data;

  logic [DATA-1:0] mem     [DEPTH];
  logic [DATA-1:0] ref_mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_dma #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .m_wr(m_wr), .m_addr(m_addr), .m_din(m_din),
    .m_dout(m_dout)
  );

  // Memory with a bench load port and registered read data.
  always @(posedge clk) begin
    if (ld_en)     mem[ld_addr] <= ld_data;
    else if (m_wr) mem[m_addr]  <= m_din;
    m_dout <= mem[m_addr];
  end

  // ---------------- reference model ----------------
  function automatic int f_active(input bit md, input int l);
    return md ? l : 2 * l;
  endfunction

  function automatic bit f_abort_eff(input bit md, input int l, input int c);
    return (c >= 1) && (c <= f_active(md, l));
  endfunction

  function automatic int f_words(input bit md, input int l, input int c);
    if (!f_abort_eff(md, l, c)) return l;
    return md ? c : c / 2;
  endfunction

  function automatic bit f_aborted(input bit md, input int l, input int c);
    if (!f_abort_eff(md, l, c)) return 1'b0;
    if (md) return c < l;
    return (c % 2 == 1) || (c / 2 < l);
  endfunction

  function automatic int f_done_cyc(input bit md, input int l, input int c);
    return (f_abort_eff(md, l, c) ? c : f_active(md, l)) + 1;
  endfunction

  // Ascending word-by-word transfer, so overlapping copies see earlier writes.
  task automatic model_apply(input bit md, input int s, input int d, input int words,
                             input logic [DATA-1:0] f);
    for (int i = 0; i < words; i++)
      ref_mem[(d + i) % DEPTH] = md ? f : ref_mem[(s + i) % DEPTH];
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic mem_load(input int a, input logic [DATA-1:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a[ADDR-1:0]; ld_data = v;
    ref_mem[a] = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issues one command, then watches cycle c=1.. after the accepting edge.
  task automatic run_cmd(input bit md, input int s, input int d, input int l,
                         input logic [DATA-1:0] f, input int abort_cyc,
                         input int start2_cyc, output int done_cyc,
                         output int wr_cnt, output logic ab_seen,
                         output logic busy1);
    int limit;
    limit = 2 * l + 20;
    @(negedge clk);
    mode = md; src_addr = s[ADDR-1:0]; dst_addr = d[ADDR-1:0];
    len = l[ADDR:0]; fill_data = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = ADDR'($urandom); dst_addr = ADDR'($urandom);
    fill_data = DATA'($urandom); mode = ~md; len = (ADDR+1)'($urandom_range(1, 30));
    done_cyc = -1; wr_cnt = 0; ab_seen = 1'b0; busy1 = busy;
    for (int c = 1; c <= limit; c++) begin
      abort = (c == abort_cyc);
      start = (c == start2_cyc);
      if (start) begin
        mode = ADDR'($urandom) % 2 == 0; src_addr = ADDR'($urandom);
        dst_addr = ADDR'($urandom); len = (ADDR+1)'($urandom_range(1, 30));
      end
      if (m_wr) wr_cnt++;
      if (done) begin
        done_cyc = c; ab_seen = aborted;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b1; mode = 1'b1; len = 15'd5;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0 || aborted !== 1'b0) begin n_bad++; $display("FAIL reset_done: got done=%b aborted=%b expected 0 0", done, aborted); end
    n_cmp++; if (m_wr !== 1'b0) begin n_bad++; $display("FAIL reset_m_wr: got %b expected 0", m_wr); end
    n_cmp++; if (m_addr !== '0 || m_din !== '0) begin n_bad++; $display("FAIL reset_port: got addr=%0h din=%0h expected 0 0", m_addr, m_din); end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_after: got busy=%b expected 0", busy); end
    $display("test_reset: done");
  endtask

  task automatic test_copy();
    int dc, wc; logic ab, b1;
    for (int i = 0; i < 4; i++) mem_load(100 + i, DATA'(5 + i));
    run_cmd(1'b0, 100, 200, 4, '0, 0, 0, dc, wc, ab, b1);
    model_apply(1'b0, 100, 200, 4, '0);
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL copy_busy: got %b expected 1", b1); end
    n_cmp++; if (dc !== 9) begin n_bad++; $display("FAIL copy_done_cycle: got %0d expected 9", dc); end
    n_cmp++; if (wc !== 4 || ab !== 1'b0) begin n_bad++; $display("FAIL copy_writes: got wr=%0d aborted=%b expected 4 0", wc, ab); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (mem[200 + i] !== DATA'(5 + i)) begin n_bad++; $display("FAIL copy_word%0d: got %0d expected %0d", i, mem[200 + i], 5 + i); end
    end
    n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL copy_memory: got %0d differing words expected 0", mem_diffs()); end
    $display("test_copy: src=100 dst=200 len=4 done_cycle=%0d writes=%0d", dc, wc);
  endtask

  task automatic test_fill_wrap();
    int dc, wc; logic ab, b1;
    int addrs [4] = '{16382, 16383, 0, 1};
    run_cmd(1'b1, 0, 16382, 4, 18'h2AAAA, 0, 0, dc, wc, ab, b1);
    model_apply(1'b1, 0, 16382, 4, 18'h2AAAA);
    n_cmp++; if (wc !== 4) begin n_bad++; $display("FAIL fill_wr_cycles: got %0d expected 4", wc); end
    n_cmp++; if (dc !== 5 || ab !== 1'b0) begin n_bad++; $display("FAIL fill_done: got cycle=%0d aborted=%b expected 5 0", dc, ab); end
    foreach (addrs[i]) begin
      n_cmp++; if (mem[addrs[i]] !== 18'h2AAAA) begin n_bad++; $display("FAIL fill_word@%0d: got %0h expected 2aaaa", addrs[i], mem[addrs[i]]); end
    end
    n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL fill_memory: got %0d differing words expected 0", mem_diffs()); end
    $display("test_fill_wrap: dst=16382 len=4 done_cycle=%0d writes=%0d", dc, wc);
  endtask

  task automatic test_zero_len();
    int dc, wc; logic ab, b1; int seen;
    seen = 0;
    abort = 1'b1;
    repeat (3) begin @(negedge clk); if (busy || done || m_wr) seen++; end
    abort = 1'b0;
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL idle_abort: got %0d active cycles expected 0", seen); end
    for (int md = 0; md < 2; md++) begin
      run_cmd(md[0], 10, 20, 0, 18'h3FFFF, 0, 0, dc, wc, ab, b1);
      n_cmp++; if (wc !== 0 || dc !== 1 || ab !== 1'b0) begin n_bad++; $display("FAIL zero_len_mode%0d: got wr=%0d cycle=%0d aborted=%b expected 0 1 0", md, wc, dc, ab); end
      $display("test_zero_len: mode=%0d done_cycle=%0d writes=%0d", md, dc, wc);
    end
    n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL zero_len_memory: got %0d differing words expected 0", mem_diffs()); end
  endtask

  task automatic check_cmd(input string name, input bit md, input int s, input int d,
                           input int l, input logic [DATA-1:0] f, input int ac, input int s2);
    int dc, wc; logic ab, b1; int ew;
    run_cmd(md, s, d, l, f, ac, s2, dc, wc, ab, b1);
    ew = f_words(md, l, ac);
    model_apply(md, s, d, ew, f);
    n_cmp++; if (wc !== ew) begin n_bad++; $display("FAIL %s_writes: got %0d expected %0d", name, wc, ew); end
    n_cmp++; if (dc !== f_done_cyc(md, l, ac)) begin n_bad++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, dc, f_done_cyc(md, l, ac)); end
    n_cmp++; if (ab !== f_aborted(md, l, ac)) begin n_bad++; $display("FAIL %s_aborted: got %b expected %b", name, ab, f_aborted(md, l, ac)); end
    n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL %s_memory: got %0d differing words expected 0", name, mem_diffs()); end
    $display("%s: mode=%0d src=%0d dst=%0d len=%0d abort_cyc=%0d start2_cyc=%0d done_cycle=%0d writes=%0d aborted=%b",
             name, md, s, d, l, ac, s2, dc, wc, ab);
  endtask

  task automatic test_abort();
    check_cmd("abort_3rd_wr",  1'b0, 300, 400, 10, '0, 6, 0);
    check_cmd("abort_in_rd",   1'b0, 300, 500, 10, '0, 1, 0);
    check_cmd("abort_last_wr", 1'b0, 310, 600, 3,  '0, 6, 0);
    check_cmd("abort_fill_mid", 1'b1, 0, 700, 6, 18'h12345, 2, 0);
    check_cmd("abort_fill_last", 1'b1, 0, 800, 5, 18'h0F0F0, 5, 0);
  endtask

  task automatic test_reset_mid_fill();
    int wc, dc; logic ab, b1;
    @(negedge clk);
    mode = 1'b1; dst_addr = 14'd900; len = 15'd8; fill_data = 18'h1CAFE; start = 1'b1;
    @(negedge clk); start = 1'b0;            // 1st FILL cycle
    @(negedge clk); reset = 1'b1;            // 2nd FILL cycle
    @(negedge clk);
    n_cmp++; if (m_wr !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_fill_stop: got m_wr=%b busy=%b expected 0 0", m_wr, busy); end
    reset = 1'b0;
    wc = 0; dc = 0;
    repeat (12) begin @(negedge clk); if (m_wr) wc++; if (done) dc++; end
    model_apply(1'b1, 0, 900, 2, 18'h1CAFE);
    n_cmp++; if (wc !== 0 || dc !== 0) begin n_bad++; $display("FAIL reset_fill_quiet: got writes=%0d done=%0d expected 0 0", wc, dc); end
    n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL reset_fill_memory: got %0d differing words expected 0", mem_diffs()); end
    $display("test_reset_mid_fill: writes_after_reset=%0d done_pulses=%0d", wc, dc);
    run_cmd(1'b0, 900, 950, 3, '0, 0, 0, dc, wc, ab, b1);
    model_apply(1'b0, 900, 950, 3, '0);
    n_cmp++; if (dc !== 7 || wc !== 3) begin n_bad++; $display("FAIL reset_restart: got cycle=%0d writes=%0d expected 7 3", dc, wc); end
    n_cmp++; if (mem_diffs() !== 0) begin n_bad++; $display("FAIL reset_restart_memory: got %0d differing words expected 0", mem_diffs()); end
  endtask

  task automatic test_start_while_busy();
    check_cmd("start_busy", 1'b0, 1000, 1100, 6, '0, 0, 4);
    check_cmd("start_done", 1'b0, 1000, 1200, 2, '0, 0, 5);
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_done_queued: got busy=%b expected 0", busy); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      bit md; int s, d, l, ac, s2, act;
      logic [DATA-1:0] f;
      md = $urandom_range(0, 1) == 1;
      l  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 24);
      case ($urandom_range(0, 2))
        0: begin s = $urandom_range(0, DEPTH - 1); d = (s + $urandom_range(0, 5)) % DEPTH; end
        1: begin s = DEPTH - $urandom_range(1, 10); d = DEPTH - $urandom_range(1, 10); end
        default: begin s = $urandom_range(0, DEPTH - 1); d = $urandom_range(0, DEPTH - 1); end
      endcase
      f   = DATA'($urandom);
      act = f_active(md, l);
      ac  = (act > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, act) : 0;
      s2  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, f_done_cyc(md, l, ac)) : 0;
      check_cmd($sformatf("random%0d", it), md, s, d, l, f, ac, s2);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    // Bulk preload through the load port while reset holds the DUT idle.
    @(negedge clk);
    ld_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_addr = i[ADDR-1:0]; ld_data = DATA'($urandom); ref_mem[i] = ld_data;
      @(negedge clk);
    end
    ld_en = 1'b0;
    test_reset();
    test_copy();
    test_fill_wrap();
    test_zero_len();
    test_abort();
    test_reset_mid_fill();
    test_start_while_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
